mux4to1_rr_arbiter: RTL
=======================

// Module: mux4to1_rr_arbiter
// PURPOSE
//   Round-robin arbiter that shares one 4:1 single-bit mux output among four
//   requesters. Grants one requester at a time. Drives the mux select from the
//   registered grant. Routes the granted requester's data bit to out.
//   Sits in front of the mux4to1 datapath and is the only source of its sel.
// PARAMETERS
//   HOLD_MAX  8  max consecutive grant cycles per owner; legal 1..255.
//                Used only when MUX_ARB_TIMEOUT_EN is defined.
// PORTS
//   clk      in   1  rising-edge clock; single clock domain
//   rst_n    in   1  synchronous reset, active-low, sampled on posedge clk
//   req      in   4  request per requester; level, held until done
//   in       in   4  data bit per requester; in[i] belongs to req[i]
//   gnt      out  4  one-hot grant, registered; 4'b0000 when idle
//   sel      out  2  mux select = index of owner, registered
//   busy     out  1  registered; 1 while any grant is active (|gnt)
//   out      out  1  combinational: busy ? in[sel] : 1'b0
//   timeout  out  1  registered 1-cycle pulse on forced release
// BEHAVIOUR
//   - Reset (rst_n==0 at posedge): state=IDLE, gnt=0, sel=2'b00, busy=0,
//     timeout=0, hold_cnt=0, last=2'b11 (next search starts at requester 0).
//     Reset wins over every other event, including mid-grant; no grant survives.
//   - FSM states: IDLE, GRANT.
//   - Search order: last+1, last+2, last+3, last (mod 4, 2-bit wrap).
//     The first asserted req in that order wins.
//   - IDLE: if |req, at next posedge go to GRANT with gnt=onehot(winner),
//     sel=winner, busy=1, hold_cnt=0. Latency req->gnt is 1 cycle.
//     If req==0, stay in IDLE with outputs unchanged.
//   - GRANT, owner still requesting (req[sel]==1) and no forced release:
//     hold gnt and sel; hold_cnt increments.
//   - GRANT, owner drops req[sel] (sampled at posedge): release at that edge.
//     last=sel.
//     If other reqs are pending, grant the next winner in the same edge
//     (no idle bubble, hold_cnt=0). Otherwise go to IDLE: gnt=0, busy=0,
//     sel keeps its value.
//   - Non-owner req changes during GRANT have no effect until release.
//   - sel changes only at the edge where gnt changes; gnt is always one-hot or zero.
//   - out is a pure combinational mux of in; in[i] with i!=sel never reaches out.
// CONFIGURATION
//   MUX_ARB_TIMEOUT_EN defined:
//     - 8-bit hold_cnt is active.
//     - At the posedge ending the owner's HOLD_MAX-th consecutive grant cycle
//       (hold_cnt==HOLD_MAX-1) with req[sel] still 1: forced release.
//       last=sel; search excludes the current owner.
//     - If another requester is pending: hand off to it in the same edge and
//       pulse timeout=1 for one cycle.
//     - If no other requester is pending: owner keeps the grant, hold_cnt=0,
//       timeout stays 0.
//     - Simultaneous owner drop and count expiry is a normal release
//       (timeout=0).
//   MUX_ARB_TIMEOUT_EN undefined:
//     - No forced release; the owner holds until its req drops.
//     - timeout is tied to 0; hold_cnt is not built.
// TESTING
//   1 reset: rst_n=0 2 cycles with req=4'hF -> gnt=0, sel=0, busy=0, out=0,
//     timeout=0.
//   2 single: req=4'b0100, in=4'b0100 -> next cycle gnt=4'b0100, sel=2,
//     out=1. Drop req -> next cycle gnt=0, busy=0, sel=2.
//   3 rotation: req=4'hF held, each owner drops its bit for 1 cycle after
//     grant -> grant order 0,1,2,3,0 with no idle cycles.
//   4 mid-grant reset: owner 1 granted, rst_n=0 one cycle -> gnt=0. After
//     reset, req=4'b0011 -> grant goes to 0.
//   5 timeout (EN, HOLD_MAX=4): req=4'b0011 held -> owner 0 for 4 cycles,
//     then gnt=4'b0010 with timeout=1 for 1 cycle. Macro off: owner 0 keeps
//     the grant indefinitely.
//   6 lone owner (EN): req=4'b1000 held 20 cycles -> gnt stays 4'b1000,
//     timeout never pulses.

Source files
------------

// File: rtl/mux4to1_rr_arbiter.sv
// Round-robin arbiter owning the select of a 4:1 single-bit mux; routes the owner's data bit to out.
// Optional forced release after HOLD_MAX consecutive grant cycles when MUX_ARB_TIMEOUT_EN is defined.
module mux4to1_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] in,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       out,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     r_state, w_nxt_state;
  logic [3:0] r_gnt, w_nxt_gnt;
  logic [1:0] r_sel, w_nxt_sel;
  logic [1:0] r_last, w_nxt_last;
  logic [3:0] w_cand;
  logic [1:0] w_base;
  logic [1:0] w_win;

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
    $error("HOLD_MAX must be in 1..255");
  end

  // First asserted request after base, wrapping back to base itself last.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] idx;
    pick = base;
    for (int unsigned k = 4; k >= 1; k--) begin
      idx = base + k[1:0];
      if (r[idx]) pick = idx;
    end
  endfunction

  // During a grant the owner is masked out, so one search serves both drop and forced release.
  assign w_cand = (r_state == GRANT) ? (req & ~r_gnt) : req;
  assign w_base = (r_state == GRANT) ? r_sel : r_last;
  assign w_win  = pick(w_cand, w_base);

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] r_hold_cnt, w_nxt_cnt;
  logic       r_timeout, w_nxt_to;
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_gnt   = r_gnt;
    w_nxt_sel   = r_sel;
    w_nxt_last  = r_last;
`ifdef MUX_ARB_TIMEOUT_EN
    w_nxt_cnt   = r_hold_cnt;
    w_nxt_to    = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (|req) begin
          w_nxt_state = GRANT;
          w_nxt_gnt   = 4'b0001 << w_win;
          w_nxt_sel   = w_win;
`ifdef MUX_ARB_TIMEOUT_EN
          w_nxt_cnt   = '0;
`endif
        end
      end
      GRANT: begin
        if (!req[r_sel]) begin
          w_nxt_last = r_sel;
          if (|w_cand) begin
            w_nxt_gnt = 4'b0001 << w_win;
            w_nxt_sel = w_win;
`ifdef MUX_ARB_TIMEOUT_EN
            w_nxt_cnt = '0;
`endif
          end else begin
            w_nxt_state = IDLE;
            w_nxt_gnt   = '0;
          end
        end
`ifdef MUX_ARB_TIMEOUT_EN
        else if (r_hold_cnt == HOLD_LAST) begin
          w_nxt_last = r_sel;
          w_nxt_cnt  = '0;
          if (|w_cand) begin
            w_nxt_gnt = 4'b0001 << w_win;
            w_nxt_sel = w_win;
            w_nxt_to  = 1'b1;
          end
        end else begin
          w_nxt_cnt = r_hold_cnt + 8'd1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_sel   <= '0;
      r_last  <= '1;
    end else begin
      r_state <= w_nxt_state;
      r_gnt   <= w_nxt_gnt;
      r_sel   <= w_nxt_sel;
      r_last  <= w_nxt_last;
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_hold_cnt <= w_nxt_cnt;
      r_timeout  <= w_nxt_to;
    end
  end
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign busy = |r_gnt;
  assign out  = busy ? in[r_sel] : 1'b0;

endmodule
